// File: rtl/piano_song_sequencer.sv
// ============================================================================
// piano_song_sequencer
// ----------------------------------------------------------------------------
// Auto-play controller that sits between the keypad and the buzzer top.
// When idle it forwards the live keypad controls to the buzzer. On a start
// request it steps through a 16-entry song ROM and plays each note for
// dur x BEAT_DIV clock cycles. Any key press, or a stop request, hands the
// buzzer back to manual play at once.
//
// Optional feature:
//   PIANO_SEQ_GAP_EN - when defined, every note is followed by GAP_DIV
//                      cycles of silence (including the last note before
//                      the end of the song). When undefined, notes are
//                      contiguous and GAP_DIV is not used by the datapath.
//
// Parameters:
//   BEAT_DIV   clock cycles per beat (>= 2)
//   GAP_DIV    silent cycles between notes when gapping is built in (>= 1)
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   play_start_i   single-cycle request to start the song
//   play_stop_i    single-cycle request to abort the song
//   key_sel_i      live keypad note select, one-hot (bit0=do .. bit6=si)
//   key_octave_i   live octave switch
//   key_flat_i     live flat switch
//   sel_o          registered note select to the buzzer, one-hot or 0
//   octave_o       registered octave to the buzzer
//   flat_o         registered flat to the buzzer
//   busy_o         high while the sequencer owns the buzzer
//   done_o         one-cycle pulse when the song ends naturally
//   note_idx_o     ROM index currently playing
// ============================================================================
module piano_song_sequencer #(
    parameter int BEAT_DIV = 62_500_000,
    parameter int GAP_DIV  = 6_250_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       play_start_i,
    input  logic       play_stop_i,
    input  logic [6:0] key_sel_i,
    input  logic       key_octave_i,
    input  logic       key_flat_i,
    output logic [6:0] sel_o,
    output logic       octave_o,
    output logic       flat_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] note_idx_o
);

    // Wide enough to hold the longest note (7 beats) minus one.
    localparam int BEAT_W = $clog2(7 * BEAT_DIV);

    // Catch illegal divider settings at elaboration time.
    if (BEAT_DIV < 2 || GAP_DIV < 1) begin : g_badParams
        $error("piano_song_sequencer: BEAT_DIV must be >= 2 and GAP_DIV >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
`ifdef PIANO_SEQ_GAP_EN
        S_GAP  = 2'd2,
`endif
        S_END  = 2'd3
    } state_t;

    // Song ROM entry layout: {note[2:0], octave, flat, dur[2:0]}.
    // An entry with dur = 0 marks the end of the song.
    function automatic logic [7:0] romRead(input logic [3:0] idx);
        logic [7:0] e;
        case (idx)
            4'd0:    e = {3'd1, 1'b0, 1'b0, 3'd1};
            4'd1:    e = {3'd1, 1'b0, 1'b0, 3'd1};
            4'd2:    e = {3'd5, 1'b0, 1'b0, 3'd1};
            4'd3:    e = {3'd5, 1'b0, 1'b0, 3'd1};
            4'd4:    e = {3'd6, 1'b0, 1'b0, 3'd1};
            4'd5:    e = {3'd6, 1'b0, 1'b0, 3'd1};
            4'd6:    e = {3'd5, 1'b0, 1'b0, 3'd2};
            4'd7:    e = {3'd4, 1'b0, 1'b0, 3'd1};
            4'd8:    e = {3'd4, 1'b0, 1'b0, 3'd1};
            4'd9:    e = {3'd3, 1'b0, 1'b0, 3'd1};
            4'd10:   e = {3'd3, 1'b0, 1'b0, 3'd1};
            4'd11:   e = {3'd2, 1'b0, 1'b0, 3'd1};
            4'd12:   e = {3'd2, 1'b0, 1'b0, 3'd1};
            4'd13:   e = {3'd1, 1'b0, 1'b0, 3'd2};
            default: e = 8'h00;
        endcase
        return e;
    endfunction

    // Note 0 is a rest; notes 1..7 light sel bit note-1.
    function automatic logic [6:0] noteToSel(input logic [2:0] note);
        logic [6:0] s;
        if (note == 3'd0) begin
            s = 7'd0;
        end else begin
            s = 7'd1 << (note - 3'd1);
        end
        return s;
    endfunction

    state_t            state_q;
    logic [6:0]        sel_q;
    logic              octave_q;
    logic              flat_q;
    logic              busy_q;
    logic              done_q;
    logic [3:0]        noteIdx_q;
    logic [BEAT_W-1:0] beatCnt_q;
`ifdef PIANO_SEQ_GAP_EN
    localparam int GAP_W = (GAP_DIV > 1) ? $clog2(GAP_DIV) : 1;
    logic [GAP_W-1:0]  gapCnt_q;
`endif

    logic [4:0]        idxPlusOne;
    logic [3:0]        nxtIdx_d;
    logic [7:0]        nxtEntry;
    logic              nxtIsEnd_d;
    logic [6:0]        nxtSel_d;
    logic [BEAT_W-1:0] nxtBeats_d;

    // Look up the entry that would play next: index 0 when starting from
    // idle, otherwise the one after the current note. Running off index 15
    // is treated as an end marker so the index never wraps.
    always_comb begin
        idxPlusOne = {1'b0, noteIdx_q} + 5'd1;
        nxtIdx_d   = (state_q == S_IDLE) ? 4'd0 : idxPlusOne[3:0];
        nxtEntry   = romRead(nxtIdx_d);
        nxtIsEnd_d = ((state_q != S_IDLE) && idxPlusOne[4]) || (nxtEntry[2:0] == 3'd0);
        nxtSel_d   = noteToSel(nxtEntry[7:5]);
        nxtBeats_d = BEAT_W'(nxtEntry[2:0]) * BEAT_W'(BEAT_DIV) - BEAT_W'(1);
    end

    // Main sequencer. Manual play always wins: a stop request or any key
    // while busy drops straight back to idle passthrough without a done
    // pulse. Note timing counts the beat counter down to zero, so a note
    // lasts exactly dur x BEAT_DIV cycles including its first cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            sel_q     <= 7'd0;
            octave_q  <= 1'b0;
            flat_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            noteIdx_q <= 4'd0;
            beatCnt_q <= '0;
`ifdef PIANO_SEQ_GAP_EN
            gapCnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if ((state_q != S_IDLE) && (play_stop_i || (key_sel_i != 7'd0))) begin
                state_q  <= S_IDLE;
                sel_q    <= key_sel_i;
                octave_q <= key_octave_i;
                flat_q   <= key_flat_i;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        sel_q    <= key_sel_i;
                        octave_q <= key_octave_i;
                        flat_q   <= key_flat_i;
                        busy_q   <= 1'b0;
                        if (play_start_i && !play_stop_i && (key_sel_i == 7'd0)) begin
                            state_q   <= S_NOTE;
                            noteIdx_q <= nxtIdx_d;
                            sel_q     <= nxtSel_d;
                            octave_q  <= nxtEntry[4];
                            flat_q    <= nxtEntry[3];
                            beatCnt_q <= nxtBeats_d;
                            busy_q    <= 1'b1;
                        end
                    end
                    S_NOTE: begin
                        if (beatCnt_q != '0) begin
                            beatCnt_q <= beatCnt_q - BEAT_W'(1);
                        end else begin
`ifdef PIANO_SEQ_GAP_EN
                            state_q  <= S_GAP;
                            sel_q    <= 7'd0;
                            octave_q <= 1'b0;
                            flat_q   <= 1'b0;
                            gapCnt_q <= GAP_W'(GAP_DIV - 1);
`else
                            if (nxtIsEnd_d) begin
                                state_q  <= S_END;
                                sel_q    <= 7'd0;
                                octave_q <= 1'b0;
                                flat_q   <= 1'b0;
                                done_q   <= 1'b1;
                            end else begin
                                noteIdx_q <= nxtIdx_d;
                                sel_q     <= nxtSel_d;
                                octave_q  <= nxtEntry[4];
                                flat_q    <= nxtEntry[3];
                                beatCnt_q <= nxtBeats_d;
                            end
`endif
                        end
                    end
`ifdef PIANO_SEQ_GAP_EN
                    S_GAP: begin
                        if (gapCnt_q != '0) begin
                            gapCnt_q <= gapCnt_q - GAP_W'(1);
                        end else if (nxtIsEnd_d) begin
                            state_q <= S_END;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_NOTE;
                            noteIdx_q <= nxtIdx_d;
                            sel_q     <= nxtSel_d;
                            octave_q  <= nxtEntry[4];
                            flat_q    <= nxtEntry[3];
                            beatCnt_q <= nxtBeats_d;
                        end
                    end
`endif
                    S_END: begin
                        state_q  <= S_IDLE;
                        sel_q    <= key_sel_i;
                        octave_q <= key_octave_i;
                        flat_q   <= key_flat_i;
                        busy_q   <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sel_o      = sel_q;
    assign octave_o   = octave_q;
    assign flat_o     = flat_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign note_idx_o = noteIdx_q;

endmodule

// File: tb/tb_piano_song_sequencer.sv
// ============================================================================
// tb_piano_song_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for piano_song_sequencer with BEAT_DIV=4, GAP_DIV=2.
// Idle passthrough and start/stop arbitration are driven from a vector
// table; the full song, key abort, ignored restart and mid-song reset are
// hand-written sequences. Honours PIANO_SEQ_GAP_EN for the expected timing.
// ============================================================================
`timescale 1ns/1ps
module tb_piano_song_sequencer;

    localparam int BEAT_DIV = 4;
    localparam int GAP_DIV  = 2;
`ifdef PIANO_SEQ_GAP_EN
    localparam int GAP_CYCLES = 2;
    localparam int SONG_BUSY  = 93;
`else
    localparam int GAP_CYCLES = 0;
    localparam int SONG_BUSY  = 65;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       play_start;
    logic       play_stop;
    logic [6:0] key_sel;
    logic       key_octave;
    logic       key_flat;
    logic [6:0] sel;
    logic       octave;
    logic       flat;
    logic       busy;
    logic       done;
    logic [3:0] note_idx;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic [6:0] keySel;
        logic       keyOct;
        logic       keyFlat;
        logic [6:0] expSel;
        logic       expOct;
        logic       expFlat;
        logic       expBusy;
        logic       expDone;
    } vec_t;

    vec_t       vecs [9];
    logic [6:0] songSel [14];
    int         songDur [14];

    piano_song_sequencer #(
        .BEAT_DIV(BEAT_DIV),
        .GAP_DIV (GAP_DIV)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .play_start_i(play_start),
        .play_stop_i (play_stop),
        .key_sel_i   (key_sel),
        .key_octave_i(key_octave),
        .key_flat_i  (key_flat),
        .sel_o       (sel),
        .octave_o    (octave),
        .flat_o      (flat),
        .busy_o      (busy),
        .done_o      (done),
        .note_idx_o  (note_idx)
    );

    // 100 MHz bench clock; only the cycle count matters.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic stop,
                                 input logic [6:0] ks, input logic ko, input logic kf);
        play_start = start;
        play_stop  = stop;
        key_sel    = ks;
        key_octave = ko;
        key_flat   = kf;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] eSel,
                               input logic eOct, input logic eFlat,
                               input logic eBusy, input logic eDone);
        logic [10:0] actV;
        logic [10:0] expV;
        actV = {sel, octave, flat, busy, done};
        expV = {eSel, eOct, eFlat, eBusy, eDone};
        compared++;
        if (actV !== expV) begin
            mismatched++;
            $display("[TB] FAIL %s: got sel=%b oct=%b flat=%b busy=%b done=%b, want sel=%b oct=%b flat=%b busy=%b done=%b",
                     name, sel, octave, flat, busy, done, eSel, eOct, eFlat, eBusy, eDone);
        end
    endtask

    task automatic checkVal(input string name, input int actV, input int expV);
        compared++;
        if (actV != expV) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actV, expV);
        end
    endtask

    // Bounded wait for the sequencer to start playing a given ROM index.
    task automatic waitIdx(input logic [3:0] target, input string name);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (busy === 1'b1 && note_idx === target) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkVal(name, int'(found), 1);
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic pulseStop();
        applyStimulus(1'b0, 1'b1, 7'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int busyCnt;

        // Idle passthrough / arbitration vectors, each checked one cycle later.
        vecs[0] = '{1'b0, 1'b0, 7'b0000100, 1'b0, 1'b1, 7'b0000100, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 7'b1000000, 1'b1, 1'b0, 7'b1000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 7'b0000001, 1'b1, 1'b1, 7'b0000001, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 7'b0100000, 1'b0, 1'b1, 7'b0100000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 7'b0000000, 1'b1, 1'b0, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0};

        // Expected song: do do sol sol la la sol(2) fa fa mi mi re re do(2).
        songSel = '{7'b0000001, 7'b0000001, 7'b0010000, 7'b0010000, 7'b0100000,
                    7'b0100000, 7'b0010000, 7'b0001000, 7'b0001000, 7'b0000100,
                    7'b0000100, 7'b0000010, 7'b0000010, 7'b0000001};
        songDur = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};

        // ---------------- reset state and async reset ----------------
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset state", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("reset note_idx", int'(note_idx), 0);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 7'b0000010, 1'b1, 1'b0);
        tick();
        checkOutput("pre-reset passthrough", 7'b0000010, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset mid-cycle", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 7'b0000100, 1'b0, 1'b1);
        tick();
        checkOutput("passthrough after reset", 7'b0000100, 1'b0, 1'b1, 1'b0, 1'b0);

        // ---------------- idle vector table ----------------
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].keySel, vecs[i].keyOct, vecs[i].keyFlat);
            tick();
            checkOutput($sformatf("idle vec%0d", i), vecs[i].expSel, vecs[i].expOct,
                        vecs[i].expFlat, vecs[i].expBusy, vecs[i].expDone);
        end
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        tick();

        // ---------------- full song ----------------
        pulseStart();
        busyCnt = 0;
        for (int i = 0; i < 14; i++) begin
            for (int c = 0; c < songDur[i] * BEAT_DIV; c++) begin
                checkOutput($sformatf("song idx%0d cyc%0d", i, c), songSel[i], 1'b0, 1'b0, 1'b1, 1'b0);
                checkVal($sformatf("song note_idx%0d cyc%0d", i, c), int'(note_idx), i);
                busyCnt += int'(busy);
                tick();
            end
            for (int g = 0; g < GAP_CYCLES; g++) begin
                checkOutput($sformatf("song gap after idx%0d", i), 7'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                busyCnt += int'(busy);
                tick();
            end
        end
        checkOutput("song end", 7'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        busyCnt += int'(busy);
        tick();
        checkOutput("song after end", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("song busy cycles", busyCnt, SONG_BUSY);
        tick();
        checkOutput("song idle again", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- abort by key during idx3 ----------------
        pulseStart();
        waitIdx(4'd3, "reach idx3");
        applyStimulus(1'b0, 1'b0, 7'b1000000, 1'b0, 1'b0);
        tick();
        checkOutput("key abort", 7'b1000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("key abort held", 7'b1000000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        tick();
        checkOutput("key abort released", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- play_start while busy is ignored ----------------
        pulseStart();
        waitIdx(4'd5, "reach idx5");
        pulseStart();
        checkOutput("restart ignored", 7'b0100000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkVal("restart keeps idx5", int'(note_idx), 5);
        for (int c = 0; c < 20; c++) begin
            if (note_idx !== 4'd5) break;
            tick();
        end
        checkVal("continues to idx6", int'(note_idx), 6);
        checkOutput("idx6 note", 7'b0010000, 1'b0, 1'b0, 1'b1, 1'b0);
        pulseStop();
        checkOutput("stop abort", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("stop no done", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- reset mid-song at idx9 ----------------
        pulseStart();
        waitIdx(4'd9, "reach idx9");
        #2 rst = 1'b1;
        #1;
        checkOutput("mid-song reset", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("mid-song reset note_idx", int'(note_idx), 0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("idle after reset", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulseStart();
        checkOutput("restart after reset", 7'b0000001, 1'b0, 1'b0, 1'b1, 1'b0);
        checkVal("restart idx0", int'(note_idx), 0);
        tick();
        tick();
        checkVal("restart still idx0", int'(note_idx), 0);
        pulseStop();
        checkOutput("final stop", 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
